// File: rtl/lc4_mem_pkg.sv
// Shared definitions for the LC4 instruction-memory responder: word width,
// the XOR pattern key and the {data, addr} record carried down the pipeline.
package lc4_mem_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] XOR_KEY = 16'hAAAA;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [WORD_W-1:0] addr;
   } stage_t;

endpackage

// File: rtl/lc4_delay_line.sv
// Enable-gated shift register of DEPTH entries, WIDTH bits each.
// A low clr_n at a clock edge zeroes every entry, whatever the enable.
module lc4_delay_line #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;
   logic [DEPTH-1:0][WIDTH-1:0] stage_d;

   // Next pipeline contents: clear wins, otherwise shift one place when enabled.
   always_comb begin
      stage_d = stage_q;
      if (!clr_n) begin
         stage_d = '0;
      end else if (en) begin
         stage_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   // Pipeline register.
   always_ff @(posedge clk) begin
      stage_q <= stage_d;
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/lc4_imem_responder.sv
// Memory-side responder for the LC4 instruction-cache refill port.
// Each gwe-enabled edge samples mem_iaddr, looks up its word and pushes the
// {data, addr} record into a LATENCY-deep pipeline; the last stage drives the
// outputs. mem_ivalid rises once LATENCY post-reset samples have been taken.
// Build option LC4_IMEM_XOR_PATTERN_EN: when defined the word is the address
// XORed with a fixed key and no backing store exists; otherwise a
// 2**DEPTH_LOG2-word store, written through the load port, supplies the word.
module lc4_imem_responder
   import lc4_mem_pkg::*;
#(
   parameter int LATENCY    = 8,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gwe,
   input  logic [WORD_W-1:0] mem_iaddr,
   output logic [WORD_W-1:0] mem_idata,
   output logic [WORD_W-1:0] mem_iaddr_echo,
   output logic              mem_ivalid,
   input  logic              load_en,
   input  logic [WORD_W-1:0] load_addr,
   input  logic [WORD_W-1:0] load_data
);

   localparam int FILL_W = $clog2(LATENCY + 1);

   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] fill_d;
   logic [WORD_W-1:0] lookup_word;
   stage_t            stage_in;
   stage_t            stage_out;

`ifdef LC4_IMEM_XOR_PATTERN_EN
   logic unused_load;

   assign lookup_word = mem_iaddr ^ XOR_KEY;
   assign unused_load = ^{load_en, load_addr, load_data, DEPTH_LOG2[0]};
`else
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [WORD_W-1:0]     store_mem [DEPTH];
   logic                  store_we;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic                  unused_addr_hi;

   // Upper address bits alias onto the same entry.
   assign rd_idx         = mem_iaddr[DEPTH_LOG2-1:0];
   assign wr_idx         = load_addr[DEPTH_LOG2-1:0];
   assign unused_addr_hi = ^{mem_iaddr, load_addr};
   assign store_we       = rst && gwe && load_en;

   // Asynchronous read sees the contents before this edge's write, so a
   // same-edge load and lookup of one entry returns the old word.
   assign lookup_word = store_mem[rd_idx];

   // Backing store write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (store_we) begin
         store_mem[wr_idx] <= load_data;
      end
   end
`endif

   assign stage_in = '{data: lookup_word, addr: mem_iaddr};

   lc4_delay_line #(
      .WIDTH ($bits(stage_t)),
      .DEPTH (LATENCY)
   ) u_stages (
      .clk   (clk),
      .clr_n (rst),
      .en    (gwe),
      .din   (stage_in),
      .dout  (stage_out)
   );

   // Fill counter: counts enabled edges since reset, saturating at LATENCY.
   always_comb begin
      fill_d = fill_q;
      if (!rst) begin
         fill_d = '0;
      end else if (gwe && (fill_q != FILL_W'(LATENCY))) begin
         fill_d = fill_q + 1'b1;
      end
   end

   // Fill counter register.
   always_ff @(posedge clk) begin
      fill_q <= fill_d;
   end

   assign mem_idata      = stage_out.data;
   assign mem_iaddr_echo = stage_out.addr;
   assign mem_ivalid     = (fill_q == FILL_W'(LATENCY));

endmodule

// File: tb/tb_lc4_imem_responder.sv
// Self-checking bench for lc4_imem_responder. A queue scoreboard holds the
// expected {data, addr} records; one is pushed on every enabled edge and the
// oldest popped and compared against the outputs. Builds with or without
// LC4_IMEM_XOR_PATTERN_EN; the reference lookup follows the same macro.
module tb_lc4_imem_responder;
   import lc4_mem_pkg::*;

   localparam int LAT = 8;
   localparam int DLOG = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        gwe = 1'b0;
   logic [15:0] mem_iaddr = '0;
   logic [15:0] mem_idata;
   logic [15:0] mem_iaddr_echo;
   logic        mem_ivalid;
   logic        load_en = 1'b0;
   logic [15:0] load_addr = '0;
   logic [15:0] load_data = '0;

   int     total = 0;
   int     bad = 0;
   bit     chk_en = 1'b0;
   stage_t exp_q[$];
   stage_t last_exp = '0;
   int     exp_fill = 0;
   logic [15:0] ref_store [2**DLOG];

   lc4_imem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DLOG)) dut (
      .clk            (clk),
      .rst            (rst),
      .gwe            (gwe),
      .mem_iaddr      (mem_iaddr),
      .mem_idata      (mem_idata),
      .mem_iaddr_echo (mem_iaddr_echo),
      .mem_ivalid     (mem_ivalid),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data)
   );

   always #5 clk = ~clk;

   // Reference lookup: XOR pattern, or the bench's copy of the backing store.
   function automatic logic [15:0] refLookup(input logic [15:0] a);
`ifdef LC4_IMEM_XOR_PATTERN_EN
      return a ^ 16'hAAAA;
`else
      return ref_store[a[DLOG-1:0]];
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic resetScoreboard();
      exp_q.delete();
      for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
      last_exp = '0;
      exp_fill = 0;
   endtask

   // Drive one clock's inputs, update the reference at the edge, check after it.
   task automatic applyStimulus(input logic r, input logic g, input logic [15:0] a,
                                input logic le, input logic [15:0] la, input logic [15:0] ld);
      stage_t s;
      @(negedge clk);
      rst = r; gwe = g; mem_iaddr = a;
      load_en = le; load_addr = la; load_data = ld;
      @(posedge clk);
      if (!r) begin
         resetScoreboard();
      end else if (g) begin
         s.data = refLookup(a);
         s.addr = a;
         exp_q.push_back(s);
         last_exp = exp_q.pop_front();
         if (exp_fill < LAT) exp_fill++;
`ifndef LC4_IMEM_XOR_PATTERN_EN
         if (le) ref_store[la[DLOG-1:0]] = ld;
`endif
      end
      #1;
      if (chk_en) begin
         checkOutput("idata", mem_idata, last_exp.data);
         checkOutput("echo", mem_iaddr_echo, last_exp.addr);
         checkOutput("ivalid", {15'b0, mem_ivalid}, {15'b0, exp_fill == LAT});
      end
   endtask

   initial begin
      resetScoreboard();
      // Fill every store entry with a known pattern before any checked lookups.
      applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < 2**DLOG; i++)
         applyStimulus(1'b1, 1'b1, 16'h0, 1'b1, 16'(i), 16'(i * 16'h0101) ^ 16'h5A5A);
      chk_en = 1'b1;

      $display("[TB] reset and hold 0x0010");
      applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b0, 1'b0, 16'h0010, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);

      $display("[TB] consecutive addresses");
      for (int i = 0; i < 16 + LAT; i++) applyStimulus(1'b1, 1'b1, 16'(i), 1'b0, 16'h0, 16'h0);

      $display("[TB] gwe stall mid-stream");
      for (int i = 0; i < 14; i++)
         applyStimulus(1'b1, !(i >= 4 && i < 7), 16'h0030 + 16'(i), 1'b0, 16'h0, 16'h0);

      $display("[TB] reset mid-stream");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 16'h0040 + 16'(i), 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b0, 1'b1, 16'h0045, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < LAT + 3; i++) applyStimulus(1'b1, 1'b1, 16'h0050 + 16'(i), 1'b0, 16'h0, 16'h0);

      $display("[TB] load, alias and read-before-write");
      applyStimulus(1'b1, 1'b1, 16'h0007, 1'b1, 16'h0003, 16'h1234);
      applyStimulus(1'b1, 1'b1, 16'h0103, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b1, 16'h0003, 1'b1, 16'h0003, 16'h5678);
      applyStimulus(1'b1, 1'b1, 16'h0003, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b0, 16'h0003, 1'b1, 16'h0003, 16'h9999);
      applyStimulus(1'b0, 1'b1, 16'h0003, 1'b1, 16'h0003, 16'hBEEF);
      applyStimulus(1'b1, 1'b1, 16'h0003, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < LAT + 1; i++) applyStimulus(1'b1, 1'b1, 16'h0200 + 16'(i), 1'b0, 16'h0, 16'h0);

      $display("[TB] random traffic");
      for (int i = 0; i < 200; i++)
         applyStimulus($urandom_range(15, 0) != 0, $urandom_range(3, 0) != 0,
                       16'($urandom), $urandom_range(2, 0) == 0,
                       16'($urandom), 16'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
